// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer.
// Owns the program counter, keeps at most one word request in flight to
// instruction memory, and hands each fetched word plus its PC to decode.
// Execute can redirect the PC at any time; responses that belong to a
// superseded request are dropped. A misaligned redirect target parks the
// sequencer in FAULT until reset.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  // Word alignment test on the two low address bits.
  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] opc_q, opc_d;

  logic        redir_ok_s;
  logic        redir_bad_s;
  logic        capture_s;

  // Classify the redirect pulse once so the FSM can give it top priority.
  always_comb begin
    redir_ok_s  = 1'b0;
    redir_bad_s = 1'b0;
    if (redirect_valid) begin
      if (is_word_aligned(redirect_pc[1:0])) begin
        redir_ok_s = 1'b1;
      end else begin
        redir_bad_s = 1'b1;
      end
    end else begin
      redir_ok_s  = 1'b0;
      redir_bad_s = 1'b0;
    end
  end

  // Next-state, PC and drop-flag logic; redirects win over every other event.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    if (redir_bad_s && (state_q != ST_FAULT)) begin
      // PC is deliberately left untouched so the faulting context is visible.
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_REQ;
          if (redir_ok_s) begin
            pc_d = redirect_pc;
          end else begin
            pc_d = pc_q;
          end
        end

        ST_REQ: begin
          if (redir_ok_s) begin
            pc_d = redirect_pc;
            if (imem_ready) begin
              // The old-address request was accepted anyway: its data must
              // be thrown away when it comes back.
              drop_d  = 1'b1;
              state_d = ST_WAIT;
            end else begin
              state_d = ST_REQ;
            end
          end else if (imem_ready) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_REQ;
          end
        end

        ST_WAIT: begin
          if (redir_ok_s) begin
            pc_d = redirect_pc;
            if (imem_rvalid) begin
              // The pending response is consumed (and discarded) right now,
              // so nothing is left in flight to drop later.
              drop_d  = 1'b0;
              state_d = ST_REQ;
            end else begin
              drop_d  = 1'b1;
              state_d = ST_WAIT;
            end
          end else if (imem_rvalid) begin
            drop_d = 1'b0;
            if (drop_q) begin
              state_d = ST_REQ;
            end else begin
              state_d = ST_HOLD;
            end
          end else begin
            state_d = ST_WAIT;
          end
        end

        ST_HOLD: begin
          if (redir_ok_s) begin
            pc_d    = redirect_pc;
            state_d = ST_REQ;
          end else if (out_ready) begin
            // Natural 32-bit wrap: 32'hFFFF_FFFC advances to 32'h0000_0000.
            pc_d    = pc_q + 32'd4;
            state_d = ST_REQ;
          end else begin
            state_d = ST_HOLD;
          end
        end

        ST_FAULT: begin
          state_d = ST_FAULT;
        end

        default: begin
          // Unreachable encoding: restart the fetch stream cleanly.
          state_d = ST_IDLE;
          drop_d  = 1'b0;
        end
      endcase
    end
  end

  // Decide when a response is captured for decode (own, in-order data only).
  always_comb begin
    capture_s = 1'b0;
    if ((state_q == ST_WAIT) && imem_rvalid && !drop_q && !redirect_valid) begin
      capture_s = 1'b1;
    end else begin
      capture_s = 1'b0;
    end
  end

  // Output holding registers: only load on capture so they stay stable in HOLD.
  always_comb begin
    instr_d = instr_q;
    opc_d   = opc_q;
    if (capture_s) begin
      instr_d = imem_rdata;
      opc_d   = pc_q;
    end else begin
      instr_d = instr_q;
      opc_d   = opc_q;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      instr_q <= 32'h0000_0000;
      opc_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
    end
  end

  // Outputs decode straight from state; out_valid is masked during a redirect
  // so decode can never accept a wrong-path instruction in that cycle.
  assign imem_req  = (state_q == ST_REQ);
  assign imem_addr = pc_q;
  assign out_valid = (state_q == ST_HOLD) && !redirect_valid;
  assign out_instr = instr_q;
  assign out_pc    = opc_q;
  assign fault     = (state_q == ST_FAULT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized bench for fetch_ctrl with a memory model, a
// program-order reference model and a scoreboard on the decode interface.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;

  fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  // Reference model: the program-order stream decode must see next.
  exp_t        exp_q[$];
  exp_t        e;
  bit          fault_exp = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_xfer = 0;
  logic [31:0] last_xfer_pc = 32'h0;
  logic [31:0] salt;

  // Memory model state.
  bit          mem_pend = 1'b0;
  bit          mem_stale = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;
  bit          accept_seen = 1'b0;
  logic [31:0] accept_addr = 32'h0;

  // Stimulus knobs and driver state.
  int          rdy_pct, rdy_delay, lat_min, lat_max, ordy_pct, ordy_delay, redir_pct;
  int          req_run = 0;
  int          hold_run = 0;
  bit          dir_pending = 1'b0;
  int          dir_cond = 0;
  logic [31:0] dir_pc = 32'h0;
  bit          redir_last = 1'b0;
  logic [31:0] redir_last_pc = 32'h0;
  bit          drv_fire;

  // Monitor history for stability checks.
  bit          held_prev = 1'b0;
  logic [31:0] prev_pc, prev_instr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic set_knobs(input int rp, input int rd, input int lmin, input int lmax,
                           input int op, input int od, input int rr);
    rdy_pct = rp; rdy_delay = rd; lat_min = lmin; lat_max = lmax;
    ordy_pct = op; ordy_delay = od; redir_pct = rr;
  endtask

  // Monitor: pops expectations on every decode transfer and checks invariants.
  always @(negedge clk) begin
    if (reset) begin
      check32("fault", {31'd0, fault}, {31'd0, fault_exp});
      if (fault_exp) begin
        check32("fault_req", {31'd0, imem_req}, 32'd0);
        check32("fault_valid", {31'd0, out_valid}, 32'd0);
      end
      if (redirect_valid) check32("redirect_gate", {31'd0, out_valid}, 32'd0);
      if (imem_req && exp_q.size() > 0) check32("imem_addr", imem_addr, exp_q[0].pc);
      if (held_prev && out_valid) begin
        check32("stable_pc", out_pc, prev_pc);
        check32("stable_instr", out_instr, prev_instr);
      end
      if (out_valid && out_ready) begin
        n_xfer++;
        last_xfer_pc = out_pc;
        if (exp_q.size() == 0) begin
          check32("xfer_unexpected", out_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check32("out_pc", out_pc, e.pc);
          check32("out_instr", out_instr, e.instr);
          exp_q.push_back(exp_t'({e.pc + 32'd4, memf(e.pc + 32'd4)}));
        end
      end
      held_prev   = out_valid && !out_ready;
      prev_pc     = out_pc;
      prev_instr  = out_instr;
      accept_seen = imem_req && imem_ready;
      accept_addr = imem_addr;
    end else begin
      held_prev   = 1'b0;
      accept_seen = 1'b0;
    end
  end

  // Driver: memory model, decode back-pressure and redirect pulses.
  always @(posedge clk) begin
    #1;
    redirect_valid = 1'b0;
    #1;
    drv_fire = 1'b0;
    if (!reset) begin
      imem_ready = 1'b0; imem_rvalid = 1'b0; out_ready = 1'b0;
      req_run = 0; hold_run = 0;
    end else begin
      if (redir_last) begin
        redir_last = 1'b0;
        exp_q.delete();
        if (redir_last_pc[1:0] == 2'b00) exp_q.push_back(exp_t'({redir_last_pc, memf(redir_last_pc)}));
        else fault_exp = 1'b1;
      end
      if (imem_rvalid) begin
        mem_pend = 1'b0; mem_stale = 1'b0;
      end
      if (accept_seen) begin
        check32("one_outstanding", {31'd0, mem_pend}, 32'd0);
        mem_pend = 1'b1; mem_stale = 1'b0; mem_addr = accept_addr;
        mem_cnt = $urandom_range(lat_max, lat_min);
        accept_seen = 1'b0;
      end else if (mem_pend) begin
        mem_cnt--;
      end
      imem_rvalid = mem_pend && (mem_cnt == 1);
      if (imem_rvalid) imem_rdata = mem_stale ? 32'hBAD0_0BAD : memf(mem_addr);
      else imem_rdata = $urandom;
      if (imem_req) begin
        imem_ready = (req_run >= rdy_delay) && ($urandom_range(99, 0) < rdy_pct);
        req_run = imem_ready ? 0 : req_run + 1;
      end else begin
        imem_ready = 1'($urandom_range(1, 0)); req_run = 0;
      end
      if (out_valid) begin
        out_ready = (hold_run >= ordy_delay) && ($urandom_range(99, 0) < ordy_pct);
        hold_run = out_ready ? 0 : hold_run + 1;
      end else begin
        out_ready = 1'($urandom_range(1, 0)); hold_run = 0;
      end
      if (dir_pending && !fault_exp) begin
        case (dir_cond)
          0: drv_fire = 1'b1;
          1: drv_fire = mem_pend && !mem_stale && !imem_rvalid;
          2: drv_fire = imem_req && imem_ready;
          3: drv_fire = out_valid && out_ready;
          default: drv_fire = 1'b0;
        endcase
        if (drv_fire) begin
          redirect_pc = dir_pc; dir_pending = 1'b0;
        end
      end else if (!fault_exp && !dir_pending && redir_pct > 0 && $urandom_range(99, 0) < redir_pct) begin
        drv_fire = 1'b1;
        redirect_pc = $urandom;
        if ($urandom_range(3, 0) == 0) redirect_pc = 32'hFFFF_FFF0 | redirect_pc;
        redirect_pc = redirect_pc & 32'hFFFF_FFFC;
      end
      if (drv_fire) begin
        redirect_valid = 1'b1; redir_last = 1'b1; redir_last_pc = redirect_pc;
      end
    end
  end

  task automatic do_reset(input int cycles);
    @(negedge clk); #1;
    reset = 1'b0;
    accept_seen = 1'b0; redir_last = 1'b0; dir_pending = 1'b0;
    redirect_valid = 1'b0; imem_rvalid = 1'b0;
    #1;
    check32("rst_req", {31'd0, imem_req}, 32'd0);
    check32("rst_addr", imem_addr, RESET_PC);
    check32("rst_valid", {31'd0, out_valid}, 32'd0);
    check32("rst_instr", out_instr, 32'h0000_0000);
    check32("rst_pc", out_pc, RESET_PC);
    check32("rst_fault", {31'd0, fault}, 32'd0);
    repeat (cycles) @(negedge clk);
    #1;
    exp_q.delete();
    exp_q.push_back(exp_t'({RESET_PC, memf(RESET_PC)}));
    fault_exp = 1'b0;
    // A response still owed from before reset comes back one cycle after release.
    if (mem_pend) begin
      mem_stale = 1'b1; mem_cnt = 2;
    end
    reset = 1'b1;
  endtask

  task automatic wait_xfers(input int n, input int budget, input string name);
    int target;
    int c;
    target = n_xfer + n;
    c = 0;
    while (n_xfer < target && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    check32({name, "_progress"}, {31'd0, (n_xfer >= target)}, 32'd1);
  endtask

  task automatic fire_redirect(input int cond, input logic [31:0] pc, input int budget, input string name);
    int c;
    dir_cond = cond; dir_pc = pc; dir_pending = 1'b1;
    c = 0;
    while (dir_pending && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    check32({name, "_fired"}, {31'd0, dir_pending}, 32'd0);
    dir_pending = 1'b0;
  endtask

  task automatic wait_req_addr(input logic [31:0] expv, input int budget, input string name);
    int c;
    c = 0;
    do begin
      @(negedge clk); #1;
      c++;
    end while (!imem_req && c < budget);
    check32({name, "_req_addr"}, imem_addr, expv);
  endtask

  initial begin
    reset = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    salt = $urandom;
    set_knobs(100, 0, 1, 1, 100, 0, 0);

    // Zero-wait latency and throughput from reset release.
    do_reset(2);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); #1;
      check32("lat_req", {31'd0, imem_req}, {31'd0, (k % 3 == 1)});
      check32("lat_valid", {31'd0, out_valid}, {31'd0, (k % 3 == 0)});
      if (k % 3 == 0) check32("lat_pc", out_pc, RESET_PC + 32'(k / 3 - 1) * 32'd4);
    end

    // Slow memory and decode back-pressure.
    set_knobs(100, 2, 3, 3, 100, 4, 0);
    wait_xfers(6, 300, "stall");

    // Redirect while waiting for the response.
    set_knobs(100, 0, 3, 3, 100, 0, 0);
    fire_redirect(1, 32'h0000_0100, 100, "redir_wait");
    wait_req_addr(32'h0000_0100, 50, "redir_wait");
    wait_xfers(1, 50, "redir_wait");
    check32("redir_wait_pc", last_xfer_pc, 32'h0000_0100);

    // Redirect in the same cycle the old request is accepted.
    fire_redirect(2, 32'h0000_0180, 100, "redir_acc");
    wait_req_addr(32'h0000_0180, 50, "redir_acc");
    wait_xfers(1, 50, "redir_acc");
    check32("redir_acc_pc", last_xfer_pc, 32'h0000_0180);

    // Redirect in HOLD while decode is ready.
    fire_redirect(3, 32'h0000_0200, 100, "redir_hold");
    wait_xfers(1, 50, "redir_hold");
    check32("redir_hold_pc", last_xfer_pc, 32'h0000_0200);

    // PC wrap at the top of the address space.
    fire_redirect(0, 32'hFFFF_FFF8, 100, "wrap");
    wait_xfers(3, 100, "wrap");
    check32("wrap_pc", last_xfer_pc, 32'h0000_0000);

    // Misaligned redirect: sticky fault until reset.
    fire_redirect(0, 32'h0000_0102, 100, "misalign");
    @(negedge clk); #1;
    check32("misalign_fault", {31'd0, fault}, 32'd1);
    repeat (20) @(negedge clk);
    do_reset(2);

    // Reset while a response is outstanding.
    set_knobs(100, 0, 4, 4, 100, 0, 0);
    begin
      int c;
      c = 0;
      while (!(mem_pend && !mem_stale) && c < 50) begin
        @(negedge clk); #1;
        c++;
      end
      check32("rst_wait_reached", {31'd0, mem_pend}, 32'd1);
    end
    do_reset(1);
    wait_xfers(1, 50, "rst_wait");
    check32("rst_wait_first_pc", last_xfer_pc, RESET_PC);
    check32("rst_wait_fault", {31'd0, fault}, 32'd0);

    // Randomized traffic with occasional redirects and resets.
    for (int seg = 0; seg < 25; seg++) begin
      int lmin;
      lmin = $urandom_range(3, 1);
      set_knobs($urandom_range(100, 30), $urandom_range(2, 0), lmin, lmin + $urandom_range(2, 0),
                $urandom_range(100, 30), $urandom_range(3, 0), $urandom_range(5, 0));
      wait_xfers(8, 800, "random");
      if (seg % 5 == 4) do_reset($urandom_range(3, 1));
    end

    // Final misaligned redirect from random traffic.
    set_knobs(80, 0, 1, 3, 80, 0, 0);
    fire_redirect(0, ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(3, 1)), 100, "final_misalign");
    @(negedge clk); #1;
    check32("final_fault", {31'd0, fault}, 32'd1);
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
